// File: rtl/correlate_feeder.sv
// correlate_feeder: loads two sample arrays, sequences the correlator through
// clear/process/hold and captures its peak result under a valid/ack handshake.
module correlate_feeder #(
    parameter int N_SAMPLES      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [9:0]                 sample_in,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic [N_SAMPLES-1:0][9:0]  a_out,
    output logic [N_SAMPLES-1:0][9:0]  b_out,
    output logic [2:0]                 top_state,
    input  logic                       finished,
    input  logic [9:0]                 max_result,
    input  logic [11:0]                max_index,
    output logic                       result_valid,
    input  logic                       result_ack,
    output logic [9:0]                 result_value,
    output logic [11:0]                result_index,
    output logic                       timeout
);
    localparam int CW = $clog2(2 * N_SAMPLES);
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {LOAD, CLEAR, RUN, HOLD} state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [WW-1:0]               wait_q, wait_d;
    logic [N_SAMPLES-1:0][9:0]   a_q, a_d, b_q, b_d;
    logic                        rv_q, rv_d, to_q, to_d;
    logic [9:0]                  val_q, val_d;
    logic [11:0]                 idx_q, idx_d;

    assign sample_ready = state_q == LOAD;
    assign top_state    = state_q == RUN ? 3'b010 : state_q == HOLD ? 3'b100 : 3'b000;
    assign a_out        = a_q;
    assign b_out        = b_q;
    assign result_valid = rv_q;
    assign result_value = val_q;
    assign result_index = idx_q;
    assign timeout      = to_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        a_d     = a_q;
        b_d     = b_q;
        rv_d    = rv_q;
        to_d    = to_q;
        val_d   = val_q;
        idx_d   = idx_q;
        case (state_q)
            LOAD: if (sample_valid) begin
                // top counter bit selects the B array, low bits the slot
                if (cnt_q[CW-1]) b_d[cnt_q[CW-2:0]] = sample_in;
                else a_d[cnt_q[CW-2:0]] = sample_in;
                cnt_d = cnt_q + 1'b1;
                to_d  = 1'b0;
                if (cnt_q == CW'(2 * N_SAMPLES - 1)) begin
                    cnt_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                wait_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                wait_d = wait_q + 1'b1;
                if (finished) begin
                    val_d   = max_result;
                    idx_d   = max_index;
                    rv_d    = 1'b1;
                    to_d    = 1'b0;
                    state_d = HOLD;
                end else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    val_d   = '0;
                    idx_d   = 12'hFFF;
                    rv_d    = 1'b1;
                    to_d    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: if (result_ack && rv_q) begin
                rv_d    = 1'b0;
                state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            wait_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rv_q    <= 1'b0;
            to_q    <= 1'b0;
            val_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rv_q    <= rv_d;
            to_q    <= to_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_correlate_feeder.sv
// tb_correlate_feeder: randomized rounds checked every cycle against a
// phase-level model, plus literal checks of the key timing points.
module tb_correlate_feeder;
    localparam int TO = 64;
    localparam int P_LOAD = 0, P_CLR = 1, P_RUN = 2, P_HOLD = 3;

    logic             clk = 1'b0, reset = 1'b1;
    logic [9:0]       sample_in = '0;
    logic             sample_valid = 1'b0, sample_ready;
    logic [3:0][9:0]  a_out, b_out;
    logic [2:0]       top_state;
    logic             finished = 1'b0;
    logic [9:0]       max_result = '0;
    logic [11:0]      max_index = '0;
    logic             result_valid, result_ack = 1'b0;
    logic [9:0]       result_value;
    logic [11:0]      result_index;
    logic             timeout;

    correlate_feeder #(.N_SAMPLES(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .a_out(a_out), .b_out(b_out), .top_state(top_state),
        .finished(finished), .max_result(max_result), .max_index(max_index),
        .result_valid(result_valid), .result_ack(result_ack), .result_value(result_value),
        .result_index(result_index), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model state
    int              m_phase = P_LOAD, m_n = 0, m_runc = 0, m_holdc = 0;
    logic [3:0][9:0] e_a = '0, e_b = '0;
    logic            e_rv = 0, e_to = 0;
    logic [9:0]      e_val = '0;
    logic [11:0]     e_idx = '0;
    int              src[$];
    int              src_idx = 0;

    // stimulus knobs
    int              full_rate = 1, fin_delay = 10, ack_delay = 5;
    logic [9:0]      mr = 10'd30;
    logic [11:0]     mi = 12'd3;
    bit              tog = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = P_LOAD; m_n = 0; m_runc = 0; m_holdc = 0;
            e_a = '0; e_b = '0; e_rv = 0; e_to = 0; e_val = '0; e_idx = '0;
            src_idx = src.size();
        end else begin
            case (m_phase)
                P_LOAD: if (sample_valid) begin
                    if (m_n < 4) e_a[m_n] = sample_in;
                    else e_b[m_n-4] = sample_in;
                    m_n++;
                    src_idx++;
                    e_to = 0;
                    if (m_n == 8) begin m_n = 0; m_phase = P_CLR; end
                end
                P_CLR: begin m_phase = P_RUN; m_runc = 0; end
                P_RUN: begin
                    if (finished) begin
                        e_val = max_result; e_idx = max_index; e_rv = 1; e_to = 0;
                        m_phase = P_HOLD; m_holdc = 0;
                    end else if (m_runc + 1 == TO) begin
                        e_val = '0; e_idx = 12'hFFF; e_rv = 1; e_to = 1;
                        m_phase = P_HOLD; m_holdc = 0;
                    end
                    m_runc++;
                end
                default: if (result_ack) begin e_rv = 0; m_phase = P_LOAD; end
                         else m_holdc++;
            endcase
        end
    end

    always @(negedge clk) begin
        tog = ~tog;
        if (m_phase == P_LOAD) begin
            sample_valid = (src_idx < src.size()) && (full_rate != 0 || tog);
            sample_in = sample_valid ? 10'(src[src_idx]) : 10'($urandom);
        end else begin
            sample_valid = $urandom_range(0, 1) == 1;
            sample_in = 10'($urandom);
        end
        finished = (m_phase == P_RUN) && (m_runc >= fin_delay);
        result_ack = (m_phase == P_HOLD) ? (m_holdc >= ack_delay) : ($urandom_range(0, 3) == 0);
        max_result = mr;
        max_index = mi;
    end

    always @(posedge clk) begin
        #2;
        chk("sample_ready", sample_ready, m_phase == P_LOAD);
        chk("top_state", top_state, m_phase == P_RUN ? 3'b010 : m_phase == P_HOLD ? 3'b100 : 3'b000);
        chk("a_out", 64'(a_out), 64'(e_a));
        chk("b_out", 64'(b_out), 64'(e_b));
        chk("result_valid", result_valid, e_rv);
        chk("result_value", result_value, e_val);
        chk("result_index", result_index, e_idx);
        chk("timeout", timeout, e_to);
    end

    task automatic wait_phase(input int p, input int lim, output int n);
        n = 0;
        while (m_phase != p && n < lim) begin
            @(posedge clk); #3;
            n++;
        end
        chk("wait_phase", m_phase, p);
    endtask

    task automatic push8(output logic [3:0][9:0] pa, output logic [3:0][9:0] pb);
        for (int i = 0; i < 8; i++) begin
            logic [9:0] v;
            v = 10'($urandom);
            if (i < 4) pa[i] = v; else pb[i-4] = v;
            src.push_back(int'(v));
        end
    endtask

    initial begin
        int n, old;
        logic [3:0][9:0] ea, eb;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", sample_ready, 1); chk("rst_top", top_state, 0);
        chk("rst_rv", result_valid, 0); chk("rst_val", result_value, 0);
        chk("rst_idx", result_index, 0); chk("rst_to", timeout, 0);
        chk("rst_a", 64'(a_out), 0); chk("rst_b", 64'(b_out), 0);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ready", sample_ready, 1); chk("idle_top", top_state, 0);

        // full-rate 1,2,3,4,4,3,2,1 with stub result 30/3 after 10 run cycles
        src.push_back(1); src.push_back(2); src.push_back(3); src.push_back(4);
        src.push_back(4); src.push_back(3); src.push_back(2); src.push_back(1);
        wait_phase(P_CLR, 20, n);
        chk("load_cycles", n, 8);
        chk("lit_a", 64'(a_out), {24'd0, 10'd4, 10'd3, 10'd2, 10'd1});
        chk("lit_b", 64'(b_out), {24'd0, 10'd1, 10'd2, 10'd3, 10'd4});
        chk("clr_ready", sample_ready, 0); chk("clr_top", top_state, 3'b000);
        @(posedge clk); #3;
        chk("run_top", top_state, 3'b010);
        wait_phase(P_HOLD, 40, n);
        chk("run_len", m_runc, 11);
        chk("lit_rv", result_valid, 1); chk("lit_val", result_value, 30);
        chk("lit_idx", result_index, 3); chk("lit_hold_top", top_state, 3'b100);
        chk("lit_to", timeout, 0);
        wait_phase(P_LOAD, 20, n);
        chk("hold_cycles", n, 6);
        chk("ack_ready", sample_ready, 1); chk("ack_rv", result_valid, 0);
        chk("ack_val_kept", result_value, 30);

        // bursty load with junk offered outside LOAD
        full_rate = 0; fin_delay = 3; ack_delay = 2; mr = 10'($urandom); mi = 12'($urandom);
        push8(ea, eb);
        wait_phase(P_CLR, 40, n);
        chk("burst_a", 64'(a_out), 64'(ea)); chk("burst_b", 64'(b_out), 64'(eb));
        wait_phase(P_HOLD, 40, n);
        chk("burst_a_run", 64'(a_out), 64'(ea)); chk("burst_b_run", 64'(b_out), 64'(eb));
        wait_phase(P_LOAD, 20, n);

        // watchdog timeout
        full_rate = 1; fin_delay = 1000; ack_delay = 1;
        push8(ea, eb);
        wait_phase(P_HOLD, 120, n);
        chk("to_run_len", m_runc, 64);
        chk("to_rv", result_valid, 1); chk("to_flag", timeout, 1);
        chk("to_val", result_value, 0); chk("to_idx", result_index, 12'hFFF);
        wait_phase(P_LOAD, 20, n);
        chk("to_kept", timeout, 1);
        fin_delay = 63; mi = 12'h5A5;
        old = src_idx;
        push8(ea, eb);
        n = 0;
        while (src_idx == old && n < 20) begin @(posedge clk); #3; n++; end
        chk("to_cleared", timeout, 0);
        // finished on the watchdog's last cycle wins
        wait_phase(P_HOLD, 120, n);
        chk("prio_run_len", m_runc, 64);
        chk("prio_to", timeout, 0); chk("prio_idx", result_index, 12'h5A5);
        wait_phase(P_LOAD, 20, n);

        repeat (25) begin
            full_rate = $urandom_range(0, 1);
            fin_delay = $urandom_range(0, 70);
            ack_delay = $urandom_range(0, 4);
            mr = 10'($urandom); mi = 12'($urandom);
            push8(ea, eb);
            wait_phase(P_HOLD, 200, n);
            wait_phase(P_LOAD, 20, n);
        end

        // reset three cycles into RUN
        fin_delay = 1000; full_rate = 1;
        push8(ea, eb);
        wait_phase(P_RUN, 40, n);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_top", top_state, 0); chk("mid_ready", sample_ready, 1);
        chk("mid_rv", result_valid, 0); chk("mid_a", 64'(a_out), 0);
        chk("mid_b", 64'(b_out), 0); chk("mid_idx", result_index, 0);
        @(negedge clk) reset = 1'b0;
        repeat (80) @(posedge clk);
        #3;
        chk("mid_no_result", result_valid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
